// File: rtl/ddr_pkg.sv
// Shared types and constants for the step-judging datapath.
package ddr_pkg;

  typedef enum logic [1:0] {
    JUDGE_MISS    = 2'd0,
    JUDGE_GOOD    = 2'd1,
    JUDGE_PERFECT = 2'd2
  } judge_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPEN = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  localparam int DIR_LEFT  = 0;
  localparam int DIR_UP    = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int PTS_PERFECT = 2;
  localparam int PTS_GOOD    = 1;
  localparam int COMBO_MAX   = 255;

  function automatic logic [1:0] judge_pts(judge_t j);
    case (j)
      JUDGE_PERFECT: return 2'(PTS_PERFECT);
      JUDGE_GOOD:    return 2'(PTS_GOOD);
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Step/button inputs and verdict/score outputs of hit_judge; score_bcd_o exists only with HIT_JUDGE_BCD_EN.
interface hit_judge_if #(
  parameter int SCORE_W = 14
);
  import ddr_pkg::*;

  logic               frame_i;
  logic               step_valid_i;
  logic [3:0]         step_arrows_i;
  logic [3:0]         btn_i;
  logic               judge_valid_o;
  judge_t             judge_o;
  logic [SCORE_W-1:0] score_o;
  logic [7:0]         combo_o;
  logic [7:0]         max_combo_o;
  logic               next_o;
`ifdef HIT_JUDGE_BCD_EN
  logic [15:0]        score_bcd_o;
`endif

  modport master (
    output frame_i, step_valid_i, step_arrows_i, btn_i,
    input  judge_valid_o, judge_o, score_o, combo_o, max_combo_o, next_o
`ifdef HIT_JUDGE_BCD_EN
    , input score_bcd_o
`endif
  );

  modport slave (
    input  frame_i, step_valid_i, step_arrows_i, btn_i,
    output judge_valid_o, judge_o, score_o, combo_o, max_combo_o, next_o
`ifdef HIT_JUDGE_BCD_EN
    , output score_bcd_o
`endif
  );

endinterface

// File: rtl/hit_judge_bcd.sv
// 4-digit BCD accumulator: adds 0..2 per add_i pulse, saturating at 9999.
module hit_judge_bcd (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        add_i,
  input  logic [1:0]  pts_i,
  output logic [15:0] bcd_o
);
  logic [15:0] bcd_q;
  logic [15:0] sum;
  logic [4:0]  carry;
  logic [4:0]  digit;

  always_comb begin
    sum   = '0;
    carry = 5'(pts_i);
    digit = '0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, bcd_q[4*i +: 4]} + carry;
      if (digit > 5'd9) begin
        sum[4*i +: 4] = 4'(digit - 5'd10);
        carry         = 5'd1;
      end else begin
        sum[4*i +: 4] = digit[3:0];
        carry         = 5'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q <= '0;
    end else if (add_i) begin
      bcd_q <= (carry != 5'd0) ? 16'h9999 : sum;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/hit_judge.sv
// Judges button presses against each step in the hit zone; verdict and next_o one cycle after the decision.
// Optional HIT_JUDGE_BCD_EN adds a saturating 4-digit BCD copy of the score on score_bcd_o.
module hit_judge
  import ddr_pkg::*;
#(
  parameter int WINDOW_FRAMES  = 8,
  parameter int PERFECT_FRAMES = 3,
  parameter int SCORE_W        = 14
) (
  input logic        clk_i,
  input logic        rst_ni,
  hit_judge_if.slave bus
);
  localparam int CNT_W = (WINDOW_FRAMES > 1) ? $clog2(WINDOW_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_FRAMES - 1);

  if (PERFECT_FRAMES < 1 || PERFECT_FRAMES > WINDOW_FRAMES) begin : g_bad_cfg
    $error("hit_judge: PERFECT_FRAMES must lie in 1..WINDOW_FRAMES");
  end

  state_t             state_q, state_d;
  logic [3:0]         mask_q, mask_d, pressed_q, pressed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  judge_t             verdict_q, verdict_d;
  logic               pend_q, pend_d, rest_q, rest_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0]   score_sum;
  logic [7:0]         combo_q, combo_d, max_q, max_d;
  logic [3:0]         hit;
  logic               complete;
  logic [1:0]         pts;

  assign hit       = bus.btn_i & mask_q;
  assign complete  = ((pressed_q | hit) == mask_q);
  assign pts       = judge_pts(verdict_q);
  assign score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, pts};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      pressed_q <= '0;
      cnt_q     <= '0;
      verdict_q <= JUDGE_MISS;
      pend_q    <= 1'b0;
      rest_q    <= 1'b0;
      score_q   <= '0;
      combo_q   <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      verdict_q <= verdict_d;
      pend_q    <= pend_d;
      rest_q    <= rest_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
      max_q     <= max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pressed_d = pressed_q;
    cnt_d     = cnt_q;
    verdict_d = verdict_q;
    pend_d    = pend_q;
    rest_d    = 1'b0;
    score_d   = score_q;
    combo_d   = combo_q;
    max_d     = max_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.step_valid_i) begin
          mask_d    = bus.step_arrows_i;
          cnt_d     = '0;
          pressed_d = '0;
          if (bus.step_arrows_i != 4'd0) state_d = ST_OPEN;
          else                           rest_d  = 1'b1;
        end
      end
      ST_OPEN: begin
        pressed_d = pressed_q | hit;
        // Completion beats both expiry and a superseding step; cnt is the pre-increment value.
        if (complete) begin
          state_d   = ST_EMIT;
          verdict_d = (int'(cnt_q) < PERFECT_FRAMES) ? JUDGE_PERFECT : JUDGE_GOOD;
        end else if (bus.step_valid_i || (bus.frame_i && cnt_q == CNT_LAST)) begin
          state_d   = ST_EMIT;
          verdict_d = JUDGE_MISS;
        end else if (bus.frame_i) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bus.step_valid_i) begin
          mask_d    = bus.step_arrows_i;
          cnt_d     = '0;
          pressed_d = '0;
          pend_d    = 1'b1;
        end
      end
      ST_EMIT: begin
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        combo_d = (verdict_q == JUDGE_MISS)    ? 8'd0 :
                  (combo_q == 8'(COMBO_MAX))   ? combo_q : combo_q + 8'd1;
        max_d   = (combo_d > max_q) ? combo_d : max_q;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
        // A queued step that is overtaken before it ever opened is judged MISS in a second EMIT.
        if (bus.step_valid_i && pend_q && mask_q != 4'd0) begin
          state_d   = ST_EMIT;
          verdict_d = JUDGE_MISS;
          mask_d    = bus.step_arrows_i;
          cnt_d     = '0;
          pressed_d = '0;
          pend_d    = 1'b1;
        end else if (bus.step_valid_i) begin
          mask_d    = bus.step_arrows_i;
          cnt_d     = '0;
          pressed_d = '0;
          rest_d    = pend_q || (bus.step_arrows_i == 4'd0);
          state_d   = (bus.step_arrows_i != 4'd0) ? ST_OPEN : ST_IDLE;
        end else if (pend_q) begin
          rest_d  = (mask_q == 4'd0);
          state_d = (mask_q != 4'd0) ? ST_OPEN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef HIT_JUDGE_BCD_EN
  logic [15:0] score_bcd;

  hit_judge_bcd u_bcd (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .add_i  (state_q == ST_EMIT),
    .pts_i  (pts),
    .bcd_o  (score_bcd)
  );
`endif

  always_comb begin
    bus.judge_valid_o = (state_q == ST_EMIT);
    bus.judge_o       = (state_q == ST_EMIT) ? verdict_q : JUDGE_MISS;
    bus.next_o        = (state_q == ST_EMIT) || rest_q;
    bus.score_o       = score_q;
    bus.combo_o       = combo_q;
    bus.max_combo_o   = max_q;
`ifdef HIT_JUDGE_BCD_EN
    bus.score_bcd_o   = score_bcd;
`endif
  end

endmodule
